// File: rtl/control_fsm.sv
// Multi-cycle control sequencer for the 8-bit accumulator processor.
// Walks each instruction through fixed phases and drives the datapath strobes.
module control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       acc_z,
    input  logic       go,
    output logic       pc_en,
    output logic       jump,
    output logic       acc_src,
    output logic       acc_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       halted,
    output logic [2:0] phase,
    output logic [7:0] instr_cnt
);

    typedef enum logic [2:0] {
        ST_ADDR    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_OPADDR  = 3'd3,
        ST_OPFETCH = 3'd4,
        ST_EXEC    = 3'd5,
        ST_WB      = 3'd6,
        ST_HALT    = 3'd7
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] cnt_q, cnt_d;
    logic       uses_mem;

    // Reset clears every flop at once, so all state-decoded outputs drop without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ADDR;
            op_q    <= OP_HLT;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign uses_mem = (op_q == OP_ADD) || (op_q == OP_AND) ||
                      (op_q == OP_XOR) || (op_q == OP_LDA);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        pc_en   = 1'b0;
        jump    = 1'b0;
        acc_src = 1'b0;
        acc_wr  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_ADDR:    state_d = ST_FETCH;
            ST_FETCH: begin
                op_d    = opcode;
                state_d = ST_DECODE;
            end
            ST_DECODE:  state_d = (op_q == OP_HLT) ? ST_HALT : ST_OPADDR;
            ST_OPADDR: begin
                mem_rd  = uses_mem;
                state_d = ST_OPFETCH;
            end
            ST_OPFETCH: begin
                mem_rd  = uses_mem;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                acc_wr  = uses_mem;
                acc_src = (op_q == OP_LDA);
                mem_wr  = (op_q == OP_STO);
                // Skip increment: the one output that follows an input combinationally.
                pc_en   = (op_q == OP_SKZ) && acc_z;
                state_d = ST_WB;
            end
            ST_WB: begin
                pc_en   = 1'b1;
                jump    = (op_q == OP_JMP);
                cnt_d   = cnt_q + 8'd1;
                state_d = ST_ADDR;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (go) state_d = ST_WB;
            end
            default:    state_d = ST_ADDR;
        endcase
    end

    assign phase     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: stimulus pushes per-cycle expected outputs from
// an instruction-level model; a monitor pops and compares on every falling edge.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       acc_z;
    logic       go;
    logic       pc_en, jump, acc_src, acc_wr, mem_rd, mem_wr, halted;
    logic [2:0] phase;
    logic [7:0] instr_cnt;

    control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .acc_z(acc_z), .go(go),
        .pc_en(pc_en), .jump(jump), .acc_src(acc_src), .acc_wr(acc_wr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted),
        .phase(phase), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic       pc_en;
        logic       jump;
        logic       acc_src;
        logic       acc_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       halted;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mcnt   = 0;
    bit   done   = 0;

    function automatic exp_t actual();
        exp_t a;
        a.ph = phase; a.pc_en = pc_en; a.jump = jump; a.acc_src = acc_src;
        a.acc_wr = acc_wr; a.mem_rd = mem_rd; a.mem_wr = mem_wr;
        a.halted = halted; a.cnt = instr_cnt;
        return a;
    endfunction

    // Expected output of a non-HLT instruction in a given phase.
    function automatic exp_t model(input int op, input bit z, input int ph, input int cnt);
        exp_t e;
        bit   reads;
        e = '0;
        reads = (op == 2) || (op == 3) || (op == 4) || (op == 5);
        e.ph  = 3'(ph);
        e.cnt = 8'(cnt);
        if (ph == 3 || ph == 4) e.mem_rd = reads;
        if (ph == 5) begin
            e.acc_wr  = reads;
            e.acc_src = (op == 5);
            e.mem_wr  = (op == 6);
            e.pc_en   = (op == 1) && z;
        end
        if (ph == 6) begin
            e.pc_en = 1'b1;
            e.jump  = (op == 7);
        end
        return e;
    endfunction

    task automatic step(input exp_t e, input logic [2:0] opc, input logic z, input logic g);
        opcode = opc;
        acc_z  = z;
        go     = g;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int op, input bit z);
        for (int p = 0; p < 7; p++) begin
            step(model(op, z, p, mcnt),
                 (p == 1) ? 3'(op) : 3'($urandom_range(0, 7)),
                 (p == 5) ? z : 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        mcnt = (mcnt + 1) % 256;
    endtask

    task automatic run_hlt(input int halt_cycles);
        exp_t e;
        for (int p = 0; p < 3; p++) begin
            e = '0; e.ph = 3'(p); e.cnt = 8'(mcnt);
            step(e, (p == 1) ? 3'd0 : 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
        end
        for (int i = 0; i <= halt_cycles; i++) begin
            e = '0; e.ph = 3'd7; e.halted = 1'b1; e.cnt = 8'(mcnt);
            step(e, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), (i == halt_cycles));
        end
        e = '0; e.ph = 3'd6; e.pc_en = 1'b1; e.cnt = 8'(mcnt);
        step(e, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        mcnt = (mcnt + 1) % 256;
    endtask

    task automatic direct_check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs @%0t: got ph=%0d pc=%b j=%b src=%b aw=%b rd=%b wr=%b h=%b cnt=%0d expected ph=%0d pc=%b j=%b src=%b aw=%b rd=%b wr=%b h=%b cnt=%0d",
                         $time, a.ph, a.pc_en, a.jump, a.acc_src, a.acc_wr, a.mem_rd, a.mem_wr, a.halted, a.cnt,
                         e.ph, e.pc_en, e.jump, e.acc_src, e.acc_wr, e.mem_rd, e.mem_wr, e.halted, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not complete");
            $fatal(1, "timeout");
        end
    end

    initial begin
        exp_t z;
        z = '0;
        rst = 1'b1; opcode = 3'd0; acc_z = 1'b0; go = 1'b0;
        #12;
        direct_check("reset_outputs", actual(), z);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mcnt = 0;

        run_instr(2, 1'b0);           // ADD
        run_instr(5, 1'b1);           // LDA
        run_instr(6, 1'b0);           // STO
        run_instr(1, 1'b1);           // SKZ taken
        run_instr(1, 1'b0);           // SKZ not taken
        run_instr(7, 1'b0);           // JMP
        run_instr(3, 1'b1);           // AND
        run_instr(4, 1'b0);           // XOR
        run_hlt(20);

        // Reset in the middle of STO's EXEC cycle.
        for (int p = 0; p < 5; p++)
            step(model(6, 1'b0, p, mcnt), (p == 1) ? 3'd6 : 3'd0, 1'b0, 1'b0);
        direct_check("sto_exec_before_reset", actual(), model(6, 1'b0, 5, mcnt));
        rst = 1'b1;
        #1;
        direct_check("async_reset_mid_exec", actual(), z);
        exp_q.push_back(z);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mcnt = 0;

        // Random traffic long enough to wrap the retired-instruction count.
        for (int n = 0; n < 262; n++) begin
            int op;
            op = $urandom_range(0, 7);
            if (op == 0 && ($urandom_range(0, 3) != 0)) op = 2;
            if (op == 0) run_hlt($urandom_range(0, 3));
            else         run_instr(op, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
